// File: rtl/finger_scan_sequencer.sv
// Finger scan sequencer: splits the band above the palm into five column
// zones, raster-reads each zone and thresholds its foreground pixel count.
module finger_scan_sequencer #(
    parameter int IMAGE_WIDTH  = 160,
    parameter int IMAGE_HEIGHT = 120,
    parameter int FINGER_H     = 32,
    parameter int THRESH       = 64,
    parameter int CNT_W        = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] start_of_palm_r,
    input  logic [7:0] start_of_palm_c,
    input  logic [7:0] end_of_palm_c,
    output logic       pix_rd,
    output logic [7:0] pix_row,
    output logic [7:0] pix_col,
    input  logic       pix_data,
    output logic       busy,
    output logic       done,
    output logic       thumb_status,
    output logic       index_status,
    output logic       middle_status,
    output logic       ring_status,
    output logic       pinky_status
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] SCAN   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DECIDE = 3'd4;

    localparam logic [7:0]       FH      = 8'(FINGER_H);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    logic [2:0]       state;
    logic [7:0]       sc;
    logic [7:0]       r0;
    logic [7:0]       r1;
    logic [8:0]       rem;
    logic [7:0]       w;
    logic             bad;
    logic [2:0]       zone;
    logic [7:0]       zb;
    logic [7:0]       row;
    logic [7:0]       col;
    logic             rd_q;
    logic [2:0]       zone_q;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       status;
    logic [7:0]       col_last;
    logic             accept;

    assign accept   = (state == IDLE) && start;
    assign col_last = zb + w - 8'd1;

    assign pix_rd  = (state == SCAN);
    assign pix_row = row;
    assign pix_col = col;

    assign thumb_status  = status[0];
    assign index_status  = status[1];
    assign middle_status = status[2];
    assign ring_status   = status[3];
    assign pinky_status  = status[4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sc     <= '0;
            r0     <= '0;
            r1     <= '0;
            rem    <= '0;
            w      <= '0;
            bad    <= 1'b0;
            zone   <= '0;
            zb     <= '0;
            row    <= '0;
            col    <= '0;
            rd_q   <= 1'b0;
            zone_q <= '0;
            status <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_q   <= (state == SCAN);
            zone_q <= zone;
            case (state)
                IDLE: begin
                    if (start) begin
                        sc    <= start_of_palm_c;
                        rem   <= {1'b0, end_of_palm_c}
                               - {1'b0, start_of_palm_c} + 9'd1;
                        bad   <= (start_of_palm_r == 8'd0)
                               || (end_of_palm_c < start_of_palm_c);
                        r0    <= (start_of_palm_r >= FH)
                               ? start_of_palm_r - FH : 8'd0;
                        r1    <= start_of_palm_r - 8'd1;
                        w     <= '0;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (bad) begin
                        state <= DECIDE;
                    end else if (rem >= 9'd5) begin
                        rem <= rem - 9'd5;
                        w   <= w + 8'd1;
                    end else if (w == 8'd0) begin
                        state <= DECIDE;
                    end else begin
                        zone  <= '0;
                        zb    <= sc;
                        row   <= r0;
                        col   <= sc;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Row/col stop on the final address so they hold afterwards
                    if (col != col_last) begin
                        col <= col + 8'd1;
                    end else if (row != r1) begin
                        row <= row + 8'd1;
                        col <= zb;
                    end else if (zone != 3'd4) begin
                        zone <= zone + 3'd1;
                        zb   <= zb + w;
                        col  <= zb + w;
                        row  <= r0;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= DECIDE;
                end
                DECIDE: begin
                    for (int i = 0; i < 5; i++) begin
                        status[i] <= (cnt[i] >= THR);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Returned pixel belongs to the zone of the read issued one cycle earlier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else if (rd_q && pix_data) begin
            for (int i = 0; i < 5; i++) begin
                if (zone_q == 3'(i) && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_finger_scan_sequencer.sv
// Bench for finger_scan_sequencer: image memory responder, spec-level
// read/count model and per-cycle compare of the read stream and results.
module tb_finger_scan_sequencer;

    localparam int THRESH = 64;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] start_of_palm_r;
    logic [7:0] start_of_palm_c;
    logic [7:0] end_of_palm_c;
    logic       pix_rd;
    logic [7:0] pix_row;
    logic [7:0] pix_col;
    logic       pix_data;
    logic       busy;
    logic       done;
    logic       thumb_status;
    logic       index_status;
    logic       middle_status;
    logic       ring_status;
    logic       pinky_status;

    finger_scan_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .start_of_palm_r (start_of_palm_r),
        .start_of_palm_c (start_of_palm_c),
        .end_of_palm_c   (end_of_palm_c),
        .pix_rd          (pix_rd),
        .pix_row         (pix_row),
        .pix_col         (pix_col),
        .pix_data        (pix_data),
        .busy            (busy),
        .done            (done),
        .thumb_status    (thumb_status),
        .index_status    (index_status),
        .middle_status   (middle_status),
        .ring_status     (ring_status),
        .pinky_status    (pinky_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit img [0:119][0:159];
    int exp_r[$];
    int exp_c[$];
    int checks = 0;
    int fails  = 0;
    int reads  = 0;
    int dones  = 0;

    function automatic logic [4:0] stat_vec();
        return {pinky_status, ring_status, middle_status,
                index_status, thumb_status};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Image memory: data for a read appears one cycle after the strobe
    always @(posedge clk) begin
        if (pix_rd && pix_row < 8'd120 && pix_col < 8'd160)
            pix_data <= img[pix_row][pix_col];
        else
            pix_data <= 1'b0;
    end

    // Every issued read must match the next address the model expects
    always @(negedge clk) begin
        if (rst) begin
            if (pix_rd) begin
                reads++;
                chk("rd_while_busy", busy, 1);
                if (exp_r.size() == 0) begin
                    checks++;
                    fails++;
                    if (fails <= 20)
                        $display("FAIL extra_read: got r%0d c%0d expected none",
                                 pix_row, pix_col);
                end else begin
                    chk("rd_row", pix_row, exp_r[0]);
                    chk("rd_col", pix_col, exp_c[0]);
                    void'(exp_r.pop_front());
                    void'(exp_c.pop_front());
                end
            end
            if (done) dones++;
        end
    end

    task automatic clear_img();
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++)
                img[r][c] = 1'b0;
    endtask

    task automatic fill(input int rl, input int rh, input int cl, input int ch);
        for (int r = rl; r <= rh; r++)
            for (int c = cl; c <= ch; c++)
                img[r][c] = 1'b1;
    endtask

    task automatic model(input int sr, input int sc, input int ec,
                         output int n, output int w, output logic [4:0] st);
        int span, r0, r1, cnt;
        exp_r.delete();
        exp_c.delete();
        span = ec - sc + 1;
        w  = (span > 0) ? span / 5 : 0;
        r0 = (sr >= 32) ? sr - 32 : 0;
        r1 = sr - 1;
        n  = 0;
        st = '0;
        if (sr == 0 || ec < sc || w == 0) return;
        for (int z = 0; z < 5; z++) begin
            cnt = 0;
            for (int r = r0; r <= r1; r++)
                for (int c = sc + z * w; c < sc + z * w + w; c++) begin
                    exp_r.push_back(r);
                    exp_c.push_back(c);
                    cnt += img[r][c];
                    n++;
                end
            if (cnt > 4095) cnt = 4095;
            st[z] = (cnt >= THRESH);
        end
    endtask

    task automatic run(input string tag, input int sr, input int sc, input int ec,
                       input logic [4:0] lit_st, input int lit_n,
                       input int dbl_at, input int abort_at);
        int n, w, k;
        logic [4:0] st;
        bit busy_ok;
        model(sr, sc, ec, n, w, st);
        chk({tag, "_model_status"}, st, lit_st);
        chk({tag, "_model_reads"}, n, lit_n);
        reads = 0;
        dones = 0;
        @(negedge clk);
        start_of_palm_r = 8'(sr);
        start_of_palm_c = 8'(sc);
        end_of_palm_c   = 8'(ec);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        busy_ok = 1'b1;
        while (!done && k < 5000) begin
            if (!busy) busy_ok = 1'b0;
            if (k == dbl_at) begin
                start_of_palm_r = 8'd20;
                start_of_palm_c = 8'd0;
                end_of_palm_c   = 8'd100;
                start = 1'b1;
            end
            if (k == dbl_at + 1) start = 1'b0;
            if (abort_at >= 0 && reads >= abort_at) begin
                rst = 1'b0;
                #1;
                chk({tag, "_abort_outs"},
                    {pix_rd, pix_row, pix_col, busy, done, stat_vec()}, 0);
                @(negedge clk);
                rst = 1'b1;
                repeat (20) @(negedge clk);
                chk({tag, "_abort_no_done"}, dones, 0);
                chk({tag, "_abort_idle"}, {pix_rd, busy}, 0);
                return;
            end
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_busy_until_done"}, busy_ok, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_status"}, stat_vec(), st);
        chk({tag, "_reads"}, reads, n);
        chk({tag, "_reads_left"}, exp_r.size(), 0);
        if (n == 0)
            chk({tag, "_latency_short"}, (k <= 12) ? 1 : 0, 1);
        else
            chk({tag, "_latency"},
                (k >= n + 3 + w && k <= n + 5 + w) ? 1 : 0, 1);
        repeat (5) @(negedge clk);
        chk({tag, "_single_done"}, dones, 1);
        chk({tag, "_status_hold"}, stat_vec(), st);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        start_of_palm_r = '0;
        start_of_palm_c = '0;
        end_of_palm_c   = '0;
        clear_img();
        repeat (3) @(negedge clk);
        chk("reset_outs",
            {pix_rd, pix_row, pix_col, busy, done, stat_vec()}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", {pix_rd, busy, done}, 0);

        clear_img();
        fill(8, 39, 30, 39);
        run("t1", 40, 10, 59, 5'b00100, 1600, 100, -1);

        clear_img();
        fill(0, 119, 0, 159);
        run("t2", 40, 10, 59, 5'b11111, 1600, -1, -1);

        run("t3", 0, 10, 59, 5'b00000, 0, -1, -1);

        run("t4", 40, 10, 13, 5'b00000, 0, -1, -1);

        clear_img();
        fill(8, 13, 40, 49);
        fill(14, 14, 40, 43);
        run("t5_eq", 40, 10, 59, 5'b01000, 1600, -1, -1);

        clear_img();
        fill(8, 13, 40, 49);
        fill(14, 14, 40, 42);
        run("t5_lt", 40, 10, 59, 5'b00000, 1600, -1, -1);

        clear_img();
        fill(0, 119, 155, 159);
        run("t7_rem", 10, 0, 157, 5'b00000, 1550, -1, -1);

        clear_img();
        fill(0, 119, 0, 159);
        run("t6_abort", 40, 10, 59, 5'b11111, 1600, -1, 800);
        run("t6_fresh", 40, 10, 59, 5'b11111, 1600, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
